// File: rtl/pc_pkg.sv
// pc_pkg: shared types and sizes for the 3BC fetch stage.
//   PC_W      : program counter / branch offset width
//   RAS_DEPTH : return-address stack entries (power of 2)
//   state_e   : fetch sequencer states
//   pc_t      : program counter type
package pc_pkg;

  localparam int PC_W      = 10;
  localparam int RAS_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [PC_W-1:0] pc_t;

endpackage

// File: rtl/ret_stack.sv
// ret_stack: circular return-address stack.
//   Clk, Reset   : clock, async active-high reset
//   clear_i      : empty the stack (synchronous)
//   push_i       : push data_i; when full the oldest entry is overwritten
//   pop_i        : drop the top entry (caller checks empty_o first)
//   data_i       : value to push
//   top_o        : current top entry
//   empty_o      : no valid entries
//   full_o       : RAS_DEPTH valid entries
module ret_stack
  import pc_pkg::*;
#(
  parameter int W     = PC_W,
  parameter int DEPTH = RAS_DEPTH
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  // sp_q points at the next free slot; the top is the slot just below it.
  // Both wrap modulo DEPTH, so a push on full lands on the oldest entry.
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;

  assign top_idx = sp_q - PTR_W'(1);
  assign top_o   = mem_q[top_idx];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPTH_C);

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      sp_d  = '0;
      cnt_d = '0;
    end else if (pop_i) begin
      if (!empty_o) begin
        sp_d  = sp_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (push_i) begin
      sp_d = sp_q + PTR_W'(1);
      if (!full_o) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      if (!clear_i && !pop_i && push_i) mem_q[sp_q] <= data_i;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and fetch sequencer for the 3BC processor.
//   Clk, Reset : clock, async active-high reset
//   Start      : one-cycle pulse, IDLE/DONE -> RUN with PC=0, stack and flags cleared
//   Stall      : hold everything this cycle (RUN only)
//   Halt       : go to DONE, PC holds
//   Taken      : PC <= PC + Offset (signed, modulo 2^PC_W)
//   Link       : with Taken, push PC+1
//   Ret        : PC <= popped top; on empty stack PC+1 and RasUnf set
//   Offset     : signed relative branch target
//   PC         : registered fetch address
//   Running    : state is RUN
//   Done       : state is DONE
//   RasOvf     : sticky, push while stack full
//   RasUnf     : sticky, pop while stack empty
//   StateDbg   : current sequencer state
//
// Control priority in RUN: Stall > Halt > Ret > Taken > sequential.
// Handshake: Start is a level sampled on a rising edge; it is acted on only
// in IDLE or DONE. Every other control is sampled on each RUN edge, and its
// effect on PC appears right after that same edge.
module pc_fetch
  import pc_pkg::*;
#(
  parameter int PC_W      = pc_pkg::PC_W,
  parameter int RAS_DEPTH = pc_pkg::RAS_DEPTH
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Stall,
  input  logic            Halt,
  input  logic            Taken,
  input  logic            Link,
  input  logic            Ret,
  input  logic [PC_W-1:0] Offset,
  output logic [PC_W-1:0] PC,
  output logic            Running,
  output logic            Done,
  output logic            RasOvf,
  output logic            RasUnf,
  output state_e          StateDbg
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic            ras_clear, ras_push, ras_pop;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty, ras_full;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_branch;

  assign pc_inc    = pc_q + PC_W'(1);
  // Same-width add wraps modulo 2^PC_W, which equals adding the
  // sign-extended offset and truncating.
  assign pc_branch = pc_q + Offset;

  ret_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear_i (ras_clear),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (pc_inc),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ras_clear = 1'b0;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d   = RUN;
          pc_d      = '0;
          ras_clear = 1'b1;
          ovf_d     = 1'b0;
          unf_d     = 1'b0;
        end
      end
      RUN: begin
        if (Stall) begin
          // hold everything
        end else if (Halt) begin
          state_d = DONE;
        end else if (Ret) begin
          if (!ras_empty) begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end else begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
          end
        end else if (Taken) begin
          pc_d = pc_branch;
          if (Link) begin
            ras_push = 1'b1;
            if (ras_full) ovf_d = 1'b1;
          end
        end else begin
          pc_d = pc_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign PC       = pc_q;
  assign Running  = (state_q == RUN);
  assign Done     = (state_q == DONE);
  assign RasOvf   = ovf_q;
  assign RasUnf   = unf_q;
  assign StateDbg = state_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed bench for pc_fetch.
module tb_pc_fetch;
  import pc_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0, Stall = 1'b0, Halt = 1'b0;
  logic        Taken = 1'b0, Link = 1'b0, Ret = 1'b0;
  logic [9:0]  Offset = '0;
  logic [9:0]  PC;
  logic        Running, Done, RasOvf, RasUnf;
  state_e      StateDbg;

  int checks = 0;
  int errors = 0;

  pc_fetch dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Stall    (Stall),
    .Halt     (Halt),
    .Taken    (Taken),
    .Link     (Link),
    .Ret      (Ret),
    .Offset   (Offset),
    .PC       (PC),
    .Running  (Running),
    .Done     (Done),
    .RasOvf   (RasOvf),
    .RasUnf   (RasUnf),
    .StateDbg (StateDbg)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of controls, clock it, and settle 1 time unit past the edge.
  task automatic step(input logic st, input logic sl, input logic h, input logic tk,
                      input logic lk, input logic rt, input logic [9:0] off);
    Start = st; Stall = sl; Halt = h; Taken = tk; Link = lk; Ret = rt; Offset = off;
    @(posedge Clk);
    #1;
    Start = 0; Stall = 0; Halt = 0; Taken = 0; Link = 0; Ret = 0; Offset = '0;
  endtask

  task automatic idle();       step(0, 0, 0, 0, 0, 0, '0); endtask
  task automatic start();      step(1, 0, 0, 0, 0, 0, '0); endtask
  task automatic br(input logic [9:0] off); step(0, 0, 0, 1, 0, 0, off); endtask
  task automatic bl(input logic [9:0] off); step(0, 0, 0, 1, 1, 0, off); endtask
  task automatic ret();        step(0, 0, 0, 0, 0, 1, '0); endtask
  task automatic halt();       step(0, 0, 1, 0, 0, 0, '0); endtask

  initial begin
    // reset state
    #2;
    chk("rst_pc", PC, 0);
    chk("rst_running", Running, 0);
    chk("rst_done", Done, 0);
    chk("rst_ovf", RasOvf, 0);
    chk("rst_unf", RasUnf, 0);
    chk("rst_state", StateDbg, IDLE);
    @(posedge Clk); #1;
    Reset = 0;

    // controls ignored in IDLE
    br(10'd50);
    chk("idle_ignore_pc", PC, 0);
    chk("idle_ignore_run", Running, 0);

    // start, 5 sequential cycles
    start();
    chk("start_pc", PC, 0);
    chk("start_running", Running, 1);
    repeat (5) idle();
    chk("seq5_pc", PC, 5);

    // async reset between edges
    #2 Reset = 1;
    #1;
    chk("async_rst_pc", PC, 0);
    chk("async_rst_running", Running, 0);
    chk("async_rst_state", StateDbg, IDLE);
    Reset = 0;
    @(posedge Clk); #1;
    chk("post_rst_pc", PC, 0);

    // branches
    start();
    br(10'd400);
    chk("br_to_400", PC, 400);
    br(10'h28E);            // -370
    chk("br_neg", PC, 30);
    br(10'h3DE);            // -34 : 30-34 wraps to 1020
    chk("br_wrap_low", PC, 1020);
    br(10'd10);
    chk("br_wrap_high", PC, 6);
    br(10'd1);
    chk("br_plus1", PC, 7);
    // Start during RUN ignored
    start();
    chk("start_in_run", PC, 8);
    br(10'd4);
    chk("br_to_12", PC, 12);

    // bnzl / return
    bl(10'd20);
    chk("bnzl_pc", PC, 32);
    ret();
    chk("ret_pc", PC, 13);
    step(0, 0, 0, 0, 1, 0, 10'd20);   // Link without Taken
    chk("link_no_taken_pc", PC, 14);
    ret();                            // stack must be empty
    chk("ret_empty_pc", PC, 15);
    chk("ret_empty_unf", RasUnf, 1);

    // restart clears flags; stack overflow/underflow
    halt();
    start();
    chk("restart_unf_clr", RasUnf, 0);
    bl(10'd10);  // push 1
    bl(10'd10);  // push 11
    bl(10'd10);  // push 21
    bl(10'd10);  // push 31
    chk("four_push_ovf", RasOvf, 0);
    chk("four_push_pc", PC, 40);
    bl(10'd10);  // push 41, overwrites 1
    chk("five_push_ovf", RasOvf, 1);
    chk("five_push_pc", PC, 50);
    ret(); chk("pop1", PC, 41);
    ret(); chk("pop2", PC, 31);
    ret(); chk("pop3", PC, 21);
    ret(); chk("pop4", PC, 11);
    chk("pop4_unf", RasUnf, 0);
    ret();
    chk("pop5_pc", PC, 12);
    chk("pop5_unf", RasUnf, 1);
    chk("pop5_ovf_sticky", RasOvf, 1);

    // stall and priority
    step(0, 1, 0, 1, 0, 0, 10'd100);
    chk("stall_taken_pc", PC, 12);
    chk("stall_running", Running, 1);
    step(0, 0, 1, 1, 0, 0, 10'd100);
    chk("halt_taken_pc", PC, 12);
    chk("halt_taken_done", Done, 1);
    chk("halt_taken_running", Running, 0);
    start();
    chk("restart_ovf_clr", RasOvf, 0);
    chk("restart_unf_clr2", RasUnf, 0);
    chk("restart_done_clr", Done, 0);
    bl(10'd7);                          // push 1
    chk("bl7_pc", PC, 7);
    step(0, 1, 0, 0, 0, 1, '0);         // stalled Ret: no pop
    chk("stall_ret_pc", PC, 7);
    step(0, 0, 0, 1, 1, 1, 10'd100);    // Ret wins, no push
    chk("ret_prio_pc", PC, 1);
    ret();
    chk("ret_prio_nopush_pc", PC, 2);
    chk("ret_prio_nopush_unf", RasUnf, 1);

    // Done handshake
    br(10'd55);
    chk("br_to_57", PC, 57);
    halt();
    chk("halt_pc", PC, 57);
    chk("halt_done", Done, 1);
    chk("halt_running", Running, 0);
    chk("halt_state", StateDbg, DONE);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, i[0], 1, i[1], i[2], 10'($urandom_range(1, 500)));
    end
    chk("done_hold_pc", PC, 57);
    chk("done_hold_done", Done, 1);
    start();
    chk("done_start_pc", PC, 0);
    chk("done_start_done", Done, 0);
    chk("done_start_running", Running, 1);
    chk("done_start_unf", RasUnf, 0);
    ret();                              // stack was cleared by Start
    chk("cleared_stack_pc", PC, 1);
    chk("cleared_stack_unf", RasUnf, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
